alu_operand_sequencer: RTL and testbench
========================================

# alu_operand_sequencer

Control FSM that collects operand A, operand B and the operation selector for the lab ALU from one shared switch bus. It captures each value on a single-cycle `enter` pulse and launches the ALU. It then waits a fixed settle time, captures the result and flags, and presents them to the display logic. It sits between the debounced board inputs and the ALU, and it owns the operand registers that feed the ALU.

## Interface
Parameters:
- `N`, 8, operand/result width
- `SW`, 4, selector width (taken from `din[SW-1:0]`, SW ≤ N)
- `WAIT_CYC`, 2, ALU settle cycles, ≥ 1

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `din`  in  N  shared switch data
- `enter`  in  1  single-cycle, debounced capture/advance pulse
- `cancel`  in  1  single-cycle abort pulse
- `alu_y`  in  N  ALU result
- `alu_flags`  in  4  ALU flags {N,Z,C,V}
- `a_q`  out  N  operand A to ALU
- `b_q`  out  N  operand B to ALU
- `sel_q`  out  SW  selector to ALU
- `start`  out  1  one-cycle pulse at first EXEC cycle
- `busy`  out  1  high while in EXEC
- `result_q`  out  N  captured result
- `flags_q`  out  4  captured flags
- `done`  out  1  one-cycle pulse, result_q valid
- `state_o`  out  3  state code for LEDs

## Operation
- States and codes: S_A=0, S_B=1, S_SEL=2, S_EXEC=3, S_DONE=4. Codes 5–7 are unreachable and recover to S_A.
- S_A: on `enter`, `a_q<=din` and go to S_B.
- S_B: on `enter`, `b_q<=din` and go to S_SEL.
- S_SEL: on `enter`, `sel_q<=din[SW-1:0]`, go to S_EXEC, and load the settle counter with WAIT_CYC-1.
- S_EXEC: `enter` is ignored. The counter decrements each cycle. At count 0, `result_q<=alu_y`, `flags_q<=alu_flags`, and the FSM goes to S_DONE.
- S_DONE: holds the result. On `enter`, go to S_A without latching `din`.
- `cancel` in any state: go to S_A and clear the counter. `a_q`, `b_q`, `sel_q`, `result_q` and `flags_q` are retained. In S_EXEC, no capture and no `done`.
- `enter` and `cancel` in the same cycle: `cancel` wins and nothing is latched.
- `start`, `busy`, `done` and `state_o` are all registered.
- Reset: every output is 0 and state is S_A, immediately and from any state, including mid-EXEC.

## Timing
- Each operand is latched on the `clk` edge that samples `enter`=1. The new value is visible in the next cycle.
- Execution latency, with `enter` sampled in S_SEL at cycle t:
  - `start`=1 and `busy`=1 in cycle t+1.
  - `busy` stays high through t+WAIT_CYC.
  - `result_q`/`flags_q` are updated and `done`=1 in cycle t+WAIT_CYC+1 only.
- `alu_y` is sampled at the end of cycle t+WAIT_CYC. The ALU must be stable WAIT_CYC cycles after `sel_q` changes.
- A full operation takes at least 3 `enter` pulses plus WAIT_CYC+1 cycles.

## Configuration
- Macro: `ALU_SEQ_CHAIN_EN`.
- Defined: in S_DONE, `enter` loads `a_q<=result_q` and goes directly to S_B, so results chain as an accumulator. `cancel` in S_DONE still goes to S_A.
- Undefined: S_DONE + `enter` goes to S_A and `a_q` is unchanged.

## Test plan
- Basic sequence (bench ALU model y=a+b, flags computed, N=8, WAIT_CYC=2):
  - Stimulus: reset, then enter with `din`=0x25, then 0x13, then 0x00.
  - Response: `a_q`=0x25, `b_q`=0x13, `start` one cycle after the third enter, `done` 3 cycles after it, `result_q`=0x38, `flags_q`=0000, `state_o`=4.
- Cancel in S_SEL after A=0x25 and B=0x13 -> `state_o`=0, `a_q`=0x25 and `b_q`=0x13 retained, no `start`.
- `enter`+`cancel` in the same cycle in S_B with `din`=0x77 -> `state_o`=0, `b_q` unchanged.
- Enter pulses during S_EXEC -> ignored. `done` still arrives at t+3 and `state_o` goes 3→4 only.
- Reset asserted in the second EXEC cycle -> all outputs 0 in that cycle, `state_o`=0, and no `done` after release.
- With `ALU_SEQ_CHAIN_EN`:
  - After result 0x38, enter -> `a_q`=0x38, `state_o`=1.
  - Then B=0x08 and sel=0 -> `result_q`=0x40.
  - Without the macro, the same enter -> `state_o`=0 and `a_q`=0x25.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Operand/selector sequencer for the lab ALU: collects A, B, sel from a shared bus, waits a fixed
// settle time, then captures result and flags. Define ALU_SEQ_CHAIN_EN to chain results into A.
module alu_operand_sequencer #(
  parameter int unsigned N        = 8,
  parameter int unsigned SW       = 4,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  din,
  input  logic          enter,
  input  logic          cancel,
  input  logic [N-1:0]  alu_y,
  input  logic [3:0]    alu_flags,
  output logic [N-1:0]  a_q,
  output logic [N-1:0]  b_q,
  output logic [SW-1:0] sel_q,
  output logic          start,
  output logic          busy,
  output logic [N-1:0]  result_q,
  output logic [3:0]    flags_q,
  output logic          done,
  output logic [2:0]    state_o
);

  localparam int unsigned CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  typedef enum logic [2:0] {
    StA    = 3'd0,
    StB    = 3'd1,
    StSel  = 3'd2,
    StExec = 3'd3,
    StDone = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    a_d, b_d, result_d;
  logic [SW-1:0]   sel_d;
  logic [3:0]      flags_d;
  logic            start_d, busy_d, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    result_d = result_q;
    flags_d  = flags_q;
    start_d  = 1'b0;
    done_d   = 1'b0;

    // cancel overrides everything, including a simultaneous enter
    if (cancel) begin
      state_d = StA;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StA: begin
          if (enter) begin
            a_d     = din;
            state_d = StB;
          end
        end
        StB: begin
          if (enter) begin
            b_d     = din;
            state_d = StSel;
          end
        end
        StSel: begin
          if (enter) begin
            sel_d   = din[SW-1:0];
            cnt_d   = CW'(WAIT_CYC - 1);
            start_d = 1'b1;
            state_d = StExec;
          end
        end
        StExec: begin
          if (cnt_q == '0) begin
            result_d = alu_y;
            flags_d  = alu_flags;
            done_d   = 1'b1;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StDone: begin
          if (enter) begin
`ifdef ALU_SEQ_CHAIN_EN
            a_d     = result_q;
            state_d = StB;
`else
            state_d = StA;
`endif
          end
        end
        default: begin
          state_d = StA;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d == StExec);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StA;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      start    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      start    <= start_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer with an a+b ALU model; expected results are queued
// when the selector enter is driven and checked whenever done pulses.
module tb_alu_operand_sequencer;

  localparam int unsigned N  = 8;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  din;
  logic          enter;
  logic          cancel;
  logic [N-1:0]  alu_y;
  logic [3:0]    alu_flags;
  logic [N-1:0]  a_q, b_q, result_q;
  logic [SW-1:0] sel_q;
  logic          start, busy, done;
  logic [3:0]    flags_q;
  logic [2:0]    state_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [11:0] exp_q[$];

  alu_operand_sequencer #(.N(N), .SW(SW), .WAIT_CYC(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .enter    (enter),
    .cancel   (cancel),
    .alu_y    (alu_y),
    .alu_flags(alu_flags),
    .a_q      (a_q),
    .b_q      (b_q),
    .sel_q    (sel_q),
    .start    (start),
    .busy     (busy),
    .result_q (result_q),
    .flags_q  (flags_q),
    .done     (done),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  // ALU model: y = a + b, flags {N,Z,C,V}
  logic [N:0] sum;
  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    alu_y     = sum[N-1:0];
    alu_flags = {sum[N-1], (sum[N-1:0] == '0), sum[N],
                 (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1])};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {s[N-1:0], s[N-1], (s[N-1:0] == '0), s[N], (a[N-1] == b[N-1]) && (s[N-1] != a[N-1])};
  endfunction

  // all tasks start and end just after a falling edge
  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic enter_pulse(input logic [N-1:0] d);
    din   = d;
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
  endtask

  task automatic cancel_pulse();
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_state"}, 32'(state_o), 0);
    check_eq({tag, "_a"}, 32'(a_q), 0);
    check_eq({tag, "_b"}, 32'(b_q), 0);
    check_eq({tag, "_sel"}, 32'(sel_q), 0);
    check_eq({tag, "_res"}, 32'({result_q, flags_q}), 0);
    check_eq({tag, "_ctl"}, 32'({start, busy, done}), 0);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", 32'(done), 0);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check_eq("result", 32'(result_q), 32'(e[11:4]));
        check_eq("flags", 32'(flags_q), 32'(e[3:0]));
      end
    end
  end

  initial begin
    reset = 1'b1; din = '0; enter = 1'b0; cancel = 1'b0;
    cycle();
    cycle();
    check_idle_outputs("reset");
    reset = 1'b0;
    cycle();

    // basic sequence
    enter_pulse(8'h25);
    check_eq("a_latch", 32'(a_q), 32'h25);
    check_eq("st_b", 32'(state_o), 1);
    enter_pulse(8'h13);
    check_eq("b_latch", 32'(b_q), 32'h13);
    check_eq("st_sel", 32'(state_o), 2);
    exp_q.push_back(model(8'h25, 8'h13));
    enter_pulse(8'h00);
    check_eq("t1_ctl", 32'({start, busy, done}), 32'b110);
    check_eq("t1_st", 32'(state_o), 3);
    cycle();
    check_eq("t2_ctl", 32'({start, busy, done}), 32'b010);
    cycle();
    check_eq("t3_ctl", 32'({start, busy, done}), 32'b001);
    check_eq("t3_st", 32'(state_o), 4);
    check_eq("res_38", 32'({result_q, flags_q}), 32'h380);
    cycle();
    check_eq("t4_done", 32'(done), 0);

    // enter from S_DONE
    enter_pulse(8'h55);
`ifdef ALU_SEQ_CHAIN_EN
    check_eq("chain_st", 32'(state_o), 1);
    check_eq("chain_a", 32'(a_q), 32'h38);
    enter_pulse(8'h08);
    exp_q.push_back(model(8'h38, 8'h08));
    enter_pulse(8'h00);
    cycle();
    cycle();
    check_eq("chain_done", 32'({done, state_o}), 32'b1100);
    check_eq("chain_res", 32'(result_q), 32'h40);
    cancel_pulse();
`else
    check_eq("nochain_st", 32'(state_o), 0);
    check_eq("nochain_a", 32'(a_q), 32'h25);
`endif
    check_eq("back_to_a", 32'(state_o), 0);

    // cancel in S_SEL
    enter_pulse(8'h25);
    enter_pulse(8'h13);
    cancel_pulse();
    check_eq("cxl_st", 32'(state_o), 0);
    check_eq("cxl_ab", 32'({a_q, b_q}), 32'h2513);
    for (int i = 0; i < 4; i++) begin
      check_eq("cxl_nostart", 32'({start, busy}), 0);
      cycle();
    end

    // enter + cancel together in S_B
    enter_pulse(8'h11);
    din = 8'h77; enter = 1'b1; cancel = 1'b1;
    cycle();
    enter = 1'b0; cancel = 1'b0;
    check_eq("ec_st", 32'(state_o), 0);
    check_eq("ec_b", 32'(b_q), 32'h13);
    check_eq("ec_a", 32'(a_q), 32'h11);

    // enter pulses during EXEC are ignored
    enter_pulse(8'h25);
    enter_pulse(8'h13);
    exp_q.push_back(model(8'h25, 8'h13));
    enter_pulse(8'h00);
    check_eq("ex_t1_st", 32'(state_o), 3);
    enter_pulse(8'hff);
    check_eq("ex_t2", 32'({state_o, busy, done}), 32'b01110);
    enter_pulse(8'hff);
    check_eq("ex_t3", 32'({state_o, done}), 32'b1001);
    check_eq("ex_ops", 32'({a_q, b_q, 4'(sel_q)}), 32'h25130);
    cancel_pulse();

    // reset in the second EXEC cycle
    enter_pulse(8'h01);
    enter_pulse(8'h02);
    enter_pulse(8'h03);
    cycle();
    reset = 1'b1;
    #1;
    check_idle_outputs("rst_exec");
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check_eq("rst_exec_idle", 32'({state_o, busy, done}), 0);

    check_eq("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
